// File: rtl/cordic_job_arbiter.sv
// Round-robin arbiter sharing one CORDIC core between NUM_REQ requesters, one job in flight.
// Define CORDIC_ARB_STATS_EN to add saturating counters stat_jobs and stat_timeouts.
module cordic_job_arbiter #(
  parameter int unsigned NUM_REQ        = 2,
  parameter int unsigned FIXED_WIDTH    = 16,
  parameter int unsigned SHIFT_W        = 4,
  parameter int unsigned TIMEOUT_CYCLES = 64,
  localparam int unsigned IdW           = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic [NUM_REQ-1:0]             req_valid,
  output logic [NUM_REQ-1:0]             req_ready,
  input  logic [2*NUM_REQ-1:0]           req_mode,
  input  logic [NUM_REQ-1:0]             req_rot,
  input  logic [SHIFT_W*NUM_REQ-1:0]     req_shift,
  input  logic [FIXED_WIDTH*NUM_REQ-1:0] req_a,
  input  logic [FIXED_WIDTH*NUM_REQ-1:0] req_b,
  output logic                           cor_start,
  output logic [1:0]                     cor_mode,
  output logic                           cor_rot,
  output logic [SHIFT_W-1:0]             cor_shift,
  output logic [FIXED_WIDTH-1:0]         cor_a,
  output logic [FIXED_WIDTH-1:0]         cor_b,
  input  logic [FIXED_WIDTH-1:0]         cor_out1,
  input  logic [FIXED_WIDTH-1:0]         cor_out2,
  input  logic                           cor_done,
  output logic                           rsp_valid,
  input  logic                           rsp_ready,
  output logic [IdW-1:0]                 rsp_id,
  output logic [FIXED_WIDTH-1:0]         rsp_out1,
  output logic [FIXED_WIDTH-1:0]         rsp_out2,
  output logic [1:0]                     rsp_err,
  output logic                           irq
`ifdef CORDIC_ARB_STATS_EN
  ,
  output logic [31:0]                    stat_jobs,
  output logic [15:0]                    stat_timeouts
`endif
);

  localparam int unsigned CandW = IdW + 1;
  localparam logic [CandW-1:0] NumReqC = CandW'(NUM_REQ);
  localparam int unsigned WdW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [WdW-1:0] WdLimit = WdW'(TIMEOUT_CYCLES - 1);

  typedef enum logic [1:0] {StIdle, StIssue, StBusy, StResp} state_e;

  state_e           state_q;
  logic [IdW-1:0]   rr_ptr_q;
  logic [WdW-1:0]   wd_q;

  logic [CandW-1:0]       cand;
  logic [IdW-1:0]         grant_idx;
  logic                   grant_found;
  logic [IdW-1:0]         next_ptr;
  logic [1:0]             sel_mode;
  logic                   sel_rot;
  logic [SHIFT_W-1:0]     sel_shift;
  logic [FIXED_WIDTH-1:0] sel_a;
  logic [FIXED_WIDTH-1:0] sel_b;

  // First valid requester at or after rr_ptr, wrapping around.
  always_comb begin
    grant_found = 1'b0;
    grant_idx   = '0;
    cand        = '0;
    for (int unsigned i = 0; i < NUM_REQ; i++) begin
      cand = {1'b0, rr_ptr_q} + CandW'(i);
      if (cand >= NumReqC) cand = cand - NumReqC;
      if (!grant_found && req_valid[cand[IdW-1:0]]) begin
        grant_found = 1'b1;
        grant_idx   = cand[IdW-1:0];
      end
    end
  end

  always_comb begin
    sel_mode  = '0;
    sel_rot   = 1'b0;
    sel_shift = '0;
    sel_a     = '0;
    sel_b     = '0;
    for (int unsigned i = 0; i < NUM_REQ; i++) begin
      if (grant_idx == IdW'(i)) begin
        sel_mode  = req_mode[2*i +: 2];
        sel_rot   = req_rot[i];
        sel_shift = req_shift[SHIFT_W*i +: SHIFT_W];
        sel_a     = req_a[FIXED_WIDTH*i +: FIXED_WIDTH];
        sel_b     = req_b[FIXED_WIDTH*i +: FIXED_WIDTH];
      end
    end
  end

  assign next_ptr = (grant_idx == IdW'(NUM_REQ - 1)) ? '0 : grant_idx + IdW'(1);

  always_comb begin
    req_ready = '0;
    if (state_q == StIdle && grant_found) req_ready[grant_idx] = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= StIdle;
      rr_ptr_q  <= '0;
      wd_q      <= '0;
      cor_start <= 1'b0;
      cor_mode  <= '0;
      cor_rot   <= 1'b0;
      cor_shift <= '0;
      cor_a     <= '0;
      cor_b     <= '0;
      rsp_valid <= 1'b0;
      rsp_id    <= '0;
      rsp_out1  <= '0;
      rsp_out2  <= '0;
      rsp_err   <= '0;
      irq       <= 1'b0;
    end else begin
      cor_start <= 1'b0;
      irq       <= 1'b0;
      unique case (state_q)
        StIdle: begin
          if (grant_found) begin
            rr_ptr_q  <= next_ptr;
            rsp_id    <= grant_idx;
            cor_mode  <= sel_mode;
            cor_rot   <= sel_rot;
            cor_shift <= sel_shift;
            cor_a     <= sel_a;
            cor_b     <= sel_b;
            if (sel_mode == 2'd3) begin
              // Reserved mode never reaches the core.
              rsp_err   <= 2'd2;
              rsp_out1  <= '0;
              rsp_out2  <= '0;
              rsp_valid <= 1'b1;
              irq       <= 1'b1;
              state_q   <= StResp;
            end else begin
              cor_start <= 1'b1;
              state_q   <= StIssue;
            end
          end
        end
        StIssue: begin
          wd_q    <= '0;
          state_q <= StBusy;
        end
        StBusy: begin
          if (cor_done) begin
            rsp_out1  <= cor_out1;
            rsp_out2  <= cor_out2;
            rsp_err   <= 2'd0;
            rsp_valid <= 1'b1;
            irq       <= 1'b1;
            state_q   <= StResp;
          end else if (wd_q == WdLimit) begin
            rsp_out1  <= '0;
            rsp_out2  <= '0;
            rsp_err   <= 2'd1;
            rsp_valid <= 1'b1;
            irq       <= 1'b1;
            state_q   <= StResp;
          end else begin
            wd_q <= wd_q + WdW'(1);
          end
        end
        StResp: begin
          if (rsp_ready) begin
            rsp_valid <= 1'b0;
            state_q   <= StIdle;
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

`ifdef CORDIC_ARB_STATS_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      stat_jobs     <= '0;
      stat_timeouts <= '0;
    end else if (rsp_valid && rsp_ready) begin
      if (rsp_err == 2'd0 && stat_jobs != '1) stat_jobs <= stat_jobs + 32'd1;
      if (rsp_err == 2'd1 && stat_timeouts != '1) stat_timeouts <= stat_timeouts + 16'd1;
    end
  end
`endif

endmodule
